// File: rtl/vdp_vram_pkg.sv
// Shared types for the VDP VRAM read responder: address width, return tags
// and the memory request record.
package vdp_vram_pkg;

  localparam int VRAM_AW = 17;

  typedef enum logic {
    TAG_DISPLAY = 1'b0,
    TAG_CPU     = 1'b1
  } vram_tag_t;

  typedef struct packed {
    logic [VRAM_AW-1:0] address;
    logic [7:0]         wdata;
    logic               write;
  } vram_req_t;

endpackage

// File: rtl/vdp_vram_fifo.sv
// Small synchronous FIFO with a combinational head read, so the owner can
// pop and forward the head within the same cycle. DEPTH must be a power of two.
module vdp_vram_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vdp_vram_read_responder.sv
// Merges display read pulses and CPU VRAM accesses onto one memory request
// port and routes in-order read returns back to their requester.
module vdp_vram_read_responder
  import vdp_vram_pkg::*;
#(
  parameter int DISP_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VRAM_AW-1:0] vram_address,
  input  logic               vram_valid,
  output logic [7:0]         vram_rdata,
  output logic               vram_rdata_en,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic               cpu_write,
  input  logic [VRAM_AW-1:0] cpu_address,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_rdata_en,
  output logic               mem_valid,
  output logic               mem_write,
  output logic [VRAM_AW-1:0] mem_address,
  output logic [7:0]         mem_wdata,
  input  logic               mem_ready,
  input  logic               mem_rdata_en,
  input  logic [7:0]         mem_rdata,
  output logic               disp_overflow
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  vram_req_t          mem_req_q, mem_req_d;
  vram_tag_t          mem_tag_q, mem_tag_d;
  logic               mem_valid_q, mem_valid_d;
  logic [OW-1:0]      outstanding_q, outstanding_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         vram_rdata_q, vram_rdata_d, cpu_rdata_q, cpu_rdata_d;
  logic               vram_rdata_en_q, vram_rdata_en_d, cpu_rdata_en_q, cpu_rdata_en_d;

  logic [VRAM_AW-1:0] disp_head;
  logic               disp_full, disp_empty, disp_push, disp_pop, disp_bypass;
  logic [0:0]         tag_head;
  logic               tag_full, tag_empty, tag_pop;
  logic               slot_free, rd_handshake, can_read, cpu_take;
  logic [OW-1:0]      inflight;

  assign slot_free    = !mem_valid_q || mem_ready;
  assign rd_handshake = mem_valid_q && mem_ready && !mem_req_q.write;
  assign tag_pop      = mem_rdata_en && !tag_empty;

  // The read handshaking this cycle already occupies a slot for the next request.
  assign inflight = outstanding_q + OW'(rd_handshake);
  assign can_read = inflight < OW'(MAX_OUTSTANDING);

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_req_d   = mem_req_q;
    mem_tag_d   = mem_tag_q;
    disp_pop    = 1'b0;
    disp_bypass = 1'b0;
    cpu_take    = 1'b0;
    if (slot_free) begin
      mem_valid_d = 1'b0;
      // An empty FIFO is bypassed so a fresh pulse reaches memory one cycle later.
      if ((!disp_empty || vram_valid) && can_read) begin
        mem_valid_d       = 1'b1;
        mem_req_d.address = disp_empty ? vram_address : disp_head;
        mem_req_d.wdata   = '0;
        mem_req_d.write   = 1'b0;
        mem_tag_d         = TAG_DISPLAY;
        disp_pop          = !disp_empty;
        disp_bypass       = disp_empty;
      end else if (cpu_valid && (cpu_write || can_read)) begin
        mem_valid_d       = 1'b1;
        mem_req_d.address = cpu_address;
        mem_req_d.wdata   = cpu_wdata;
        mem_req_d.write   = cpu_write;
        mem_tag_d         = TAG_CPU;
        cpu_take          = 1'b1;
      end
    end
  end

  assign disp_push  = vram_valid && !disp_bypass;
  assign overflow_d = overflow_q || (disp_push && disp_full && !disp_pop);

  always_comb begin
    vram_rdata_d    = vram_rdata_q;
    cpu_rdata_d     = cpu_rdata_q;
    vram_rdata_en_d = 1'b0;
    cpu_rdata_en_d  = 1'b0;
    outstanding_d   = outstanding_q;
    if (tag_pop) begin
      if (vram_tag_t'(tag_head) == TAG_DISPLAY) begin
        vram_rdata_d    = mem_rdata;
        vram_rdata_en_d = 1'b1;
      end else begin
        cpu_rdata_d    = mem_rdata;
        cpu_rdata_en_d = 1'b1;
      end
    end
    case ({rd_handshake, tag_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q     <= 1'b0;
      mem_req_q       <= '0;
      mem_tag_q       <= TAG_DISPLAY;
      outstanding_q   <= '0;
      overflow_q      <= 1'b0;
      vram_rdata_q    <= '0;
      vram_rdata_en_q <= 1'b0;
      cpu_rdata_q     <= '0;
      cpu_rdata_en_q  <= 1'b0;
    end else begin
      mem_valid_q     <= mem_valid_d;
      mem_req_q       <= mem_req_d;
      mem_tag_q       <= mem_tag_d;
      outstanding_q   <= outstanding_d;
      overflow_q      <= overflow_d;
      vram_rdata_q    <= vram_rdata_d;
      vram_rdata_en_q <= vram_rdata_en_d;
      cpu_rdata_q     <= cpu_rdata_d;
      cpu_rdata_en_q  <= cpu_rdata_en_d;
    end
  end

  vdp_vram_fifo #(.WIDTH(VRAM_AW), .DEPTH(DISP_DEPTH)) u_disp_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (disp_push),
    .pop   (disp_pop),
    .din   (vram_address),
    .dout  (disp_head),
    .full  (disp_full),
    .empty (disp_empty)
  );

  vdp_vram_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (rd_handshake),
    .pop   (tag_pop),
    .din   (mem_tag_q),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign mem_valid     = mem_valid_q;
  assign mem_write     = mem_req_q.write;
  assign mem_address   = mem_req_q.address;
  assign mem_wdata     = mem_req_q.wdata;
  assign cpu_ready     = cpu_take && !reset && !tag_full | (cpu_take && !reset && tag_full);
  assign vram_rdata    = vram_rdata_q;
  assign vram_rdata_en = vram_rdata_en_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_rdata_en  = cpu_rdata_en_q;
  assign disp_overflow = overflow_q;

endmodule

// File: tb/tb_vdp_vram_read_responder.sv
// Directed bench for vdp_vram_read_responder: a per-cycle vector table for the
// basic display path plus hand-written multi-cycle sequences.
module tb_vdp_vram_read_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] vram_address;
  logic        vram_valid;
  logic [7:0]  vram_rdata;
  logic        vram_rdata_en;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_write;
  logic [16:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_en;
  logic        mem_valid;
  logic        mem_write;
  logic [16:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        mem_rdata_en;
  logic [7:0]  mem_rdata;
  logic        disp_overflow;

  int checks = 0;
  int errors = 0;

  vdp_vram_read_responder dut (
    .clk           (clk),
    .reset         (reset),
    .vram_address  (vram_address),
    .vram_valid    (vram_valid),
    .vram_rdata    (vram_rdata),
    .vram_rdata_en (vram_rdata_en),
    .cpu_valid     (cpu_valid),
    .cpu_ready     (cpu_ready),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_rdata_en  (cpu_rdata_en),
    .mem_valid     (mem_valid),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata_en  (mem_rdata_en),
    .mem_rdata     (mem_rdata),
    .disp_overflow (disp_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vv;
    logic [16:0] va;
    logic        rdy;
    logic        ren;
    logic [7:0]  rd;
    logic        mv;
    logic [16:0] ma;
    logic        ven;
    logic [7:0]  vd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_valid"}, 32'(mem_valid), 32'h0);
    chk({tag, " mem_address"}, 32'(mem_address), 32'h0);
    chk({tag, " vram_rdata"}, 32'(vram_rdata), 32'h0);
    chk({tag, " vram_rdata_en"}, 32'(vram_rdata_en), 32'h0);
    chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    chk({tag, " cpu_rdata_en"}, 32'(cpu_rdata_en), 32'h0);
    chk({tag, " cpu_ready"}, 32'(cpu_ready), 32'h0);
    chk({tag, " disp_overflow"}, 32'(disp_overflow), 32'h0);
  endtask

  initial begin
    // vv va rdy ren rd | mv ma ven vd
    tbl[0]  = '{1'b1, 17'h1ABCD, 1'b1, 1'b0, 8'h00, 1'b1, 17'h1ABCD, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 17'h00000, 1'b1, 1'b1, 8'h5A, 1'b0, 17'h00000, 1'b1, 8'h5A};
    tbl[3]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h5A};
    tbl[4]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h5A};
    tbl[5]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h5A};
    tbl[6]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h5A};
    tbl[7]  = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h5A};
    tbl[8]  = '{1'b1, 17'h00010, 1'b0, 1'b0, 8'h00, 1'b1, 17'h00010, 1'b0, 8'h5A};
    tbl[9]  = '{1'b0, 17'h00000, 1'b0, 1'b0, 8'h00, 1'b1, 17'h00010, 1'b0, 8'h5A};
    tbl[10] = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'h5A};
    tbl[11] = '{1'b0, 17'h00000, 1'b1, 1'b1, 8'hA5, 1'b0, 17'h00000, 1'b1, 8'hA5};
    tbl[12] = '{1'b0, 17'h00000, 1'b1, 1'b0, 8'h00, 1'b0, 17'h00000, 1'b0, 8'hA5};

    reset = 1'b0; vram_valid = 1'b0; vram_address = '0;
    cpu_valid = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata_en = 1'b0; mem_rdata = '0;
    #2 reset = 1'b1;
    #1;
    chk_all_zero("reset");
    step(); step();
    reset = 1'b0;

    // Basic display path, one vector per clock.
    for (int i = 0; i < 13; i++) begin
      vram_valid = tbl[i].vv; vram_address = tbl[i].va; mem_ready = tbl[i].rdy;
      mem_rdata_en = tbl[i].ren; mem_rdata = tbl[i].rd;
      step();
      $display("vec %0d: mem_valid=%0b mem_address=%05h vram_rdata_en=%0b vram_rdata=%02h",
               i, mem_valid, mem_address, vram_rdata_en, vram_rdata);
      chk($sformatf("vec%0d mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
      if (tbl[i].mv) begin
        chk($sformatf("vec%0d mem_address", i), 32'(mem_address), 32'(tbl[i].ma));
        chk($sformatf("vec%0d mem_write", i), 32'(mem_write), 32'h0);
      end
      chk($sformatf("vec%0d vram_rdata_en", i), 32'(vram_rdata_en), 32'(tbl[i].ven));
      chk($sformatf("vec%0d vram_rdata", i), 32'(vram_rdata), 32'(tbl[i].vd));
    end
    vram_valid = 1'b0; mem_rdata_en = 1'b0; mem_ready = 1'b1;

    // Priority and ordering: display beats a pending CPU read.
    vram_valid = 1'b1; vram_address = 17'h00200;
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_address = 17'h00100;
    #1 chk("prio cpu_ready first", 32'(cpu_ready), 32'h0);
    step();
    vram_valid = 1'b0;
    chk("prio first addr", 32'(mem_address), 32'h00200);
    #1 chk("prio cpu_ready second", 32'(cpu_ready), 32'h1);
    step();
    cpu_valid = 1'b0;
    chk("prio second addr", 32'(mem_address), 32'h00100);
    chk("prio second write", 32'(mem_write), 32'h0);
    $display("priority: display 00200 then cpu 00100 issued");
    for (int i = 0; i < 6; i++) step();
    vram_valid = 1'b1; vram_address = 17'h00300;
    step();
    vram_valid = 1'b0;
    chk("order third addr", 32'(mem_address), 32'h00300);
    step();
    chk("order idle", 32'(mem_valid), 32'h0);
    mem_rdata_en = 1'b1; mem_rdata = 8'h11; step();
    chk("ret1 vram_en", 32'(vram_rdata_en), 32'h1);
    chk("ret1 vram", 32'(vram_rdata), 32'h11);
    chk("ret1 cpu_en", 32'(cpu_rdata_en), 32'h0);
    mem_rdata = 8'h22; step();
    chk("ret2 cpu_en", 32'(cpu_rdata_en), 32'h1);
    chk("ret2 cpu", 32'(cpu_rdata), 32'h22);
    chk("ret2 vram_en", 32'(vram_rdata_en), 32'h0);
    mem_rdata = 8'h33; step();
    chk("ret3 vram_en", 32'(vram_rdata_en), 32'h1);
    chk("ret3 vram", 32'(vram_rdata), 32'h33);
    mem_rdata_en = 1'b0; step();
    chk("ret idle vram_en", 32'(vram_rdata_en), 32'h0);
    chk("ret idle cpu", 32'(cpu_rdata), 32'h22);
    $display("ordering: returns 11,22,33 routed");

    // Back-pressure: a stalled CPU write holds the slot, FIFO fills, 5th pulse drops.
    mem_ready = 1'b0;
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_address = 17'h0AAAA; cpu_wdata = 8'h77;
    #1 chk("bp cpu_ready", 32'(cpu_ready), 32'h1);
    step();
    cpu_valid = 1'b0; cpu_write = 1'b0;
    chk("bp write held", 32'(mem_write), 32'h1);
    chk("bp wdata", 32'(mem_wdata), 32'h77);
    for (int i = 0; i < 5; i++) begin
      vram_valid = 1'b1; vram_address = 17'h10000 + 17'(i);
      step();
      vram_valid = 1'b0;
      $display("bp pulse %0d: mem_address=%05h disp_overflow=%0b", i, mem_address, disp_overflow);
      chk($sformatf("bp%0d addr stable", i), 32'(mem_address), 32'h0AAAA);
      chk($sformatf("bp%0d overflow", i), 32'(disp_overflow), 32'(i == 4));
      for (int k = 0; k < 7; k++) step();
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain%0d valid", i), 32'(mem_valid), 32'h1);
      chk($sformatf("drain%0d addr", i), 32'(mem_address), 32'h10000 + i);
      chk($sformatf("drain%0d write", i), 32'(mem_write), 32'h0);
    end
    step();
    chk("drain done", 32'(mem_valid), 32'h0);

    // Outstanding limit: four reads in flight now.
    vram_valid = 1'b1; vram_address = 17'h12345;
    step();
    vram_valid = 1'b0;
    chk("limit read blocked", 32'(mem_valid), 32'h0);
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_address = 17'h05555; cpu_wdata = 8'h99;
    #1 chk("limit cpu write ready", 32'(cpu_ready), 32'h1);
    step();
    cpu_valid = 1'b0; cpu_write = 1'b0;
    chk("limit write addr", 32'(mem_address), 32'h05555);
    chk("limit write flag", 32'(mem_write), 32'h1);
    step();
    chk("limit still blocked", 32'(mem_valid), 32'h0);
    mem_rdata_en = 1'b1; mem_rdata = 8'hC1; step();
    mem_rdata_en = 1'b0;
    chk("limit ret vram", 32'(vram_rdata), 32'hC1);
    chk("limit ret blocked", 32'(mem_valid), 32'h0);
    step();
    chk("limit released valid", 32'(mem_valid), 32'h1);
    chk("limit released addr", 32'(mem_address), 32'h12345);
    chk("overflow sticky", 32'(disp_overflow), 32'h1);
    $display("limit: 12345 issued after one return");
    step();

    // Reset mid-burst with reads still in flight.
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    step();
    reset = 1'b0;
    mem_rdata_en = 1'b1; mem_rdata = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("stale%0d vram_en", i), 32'(vram_rdata_en), 32'h0);
      chk($sformatf("stale%0d cpu_en", i), 32'(cpu_rdata_en), 32'h0);
      chk($sformatf("stale%0d vram", i), 32'(vram_rdata), 32'h0);
    end
    mem_rdata_en = 1'b0;
    vram_valid = 1'b1; vram_address = 17'h00ABC;
    step();
    vram_valid = 1'b0;
    chk("post reset addr", 32'(mem_address), 32'h00ABC);
    step();
    mem_rdata_en = 1'b1; mem_rdata = 8'h3C; step();
    mem_rdata_en = 1'b0;
    chk("post reset vram_en", 32'(vram_rdata_en), 32'h1);
    chk("post reset vram", 32'(vram_rdata), 32'h3C);
    $display("reset: stale returns ignored, 00ABC returned 3c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
